reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp_if.sv | 32 +++
 rtl/reg_file_mp.sv | 129 ++++++++++++
 tb/tb_reg_file_mp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Register-file access bundle shared by the decode stage (master) and the
// register file (slave).
//   we      : write enable from the WRITE stage
//   waddr   : write destination register
//   wdata   : write data
//   raddr   : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata   : packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready   : clear sweep finished, file accepts writes
//   wr_drop : sticky, a write arrived while the file was not ready
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         we;
    logic [ADDR_WIDTH-1:0]        waddr;
    logic [DATA_WIDTH-1:0]        wdata;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic                         ready;
    logic                         wr_drop;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, ready, wr_drop
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, ready, wr_drop
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port general-purpose register file for the decode stage.
// After reset a clear sequencer writes zero to every entry, one per cycle;
// only then does the file accept writes and return real read data.
// Reads are registered (one cycle latency) with same-cycle write bypass.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : reg_file_mp_if slave (we/waddr/wdata/raddr in, rdata/ready/wr_drop out)
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    wr_drop_q, wr_drop_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic clr_en;
    logic wr_en;
    logic run;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = wr_drop_q | (bus.we & (state_q == CLEAR));
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Output decode
    always_comb begin
        clr_en = 1'b0;
        wr_en  = 1'b0;
        run    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
            end
            RUN: begin
                run   = 1'b1;
                // Writes to the hardwired zero entry are dropped silently.
                wr_en = bus.we & ~((ZERO_REG != 0) && (bus.waddr == '0));
            end
            default: begin
            end
        endcase
    end

    // Storage is deliberately not reset; the sweep zeroes it instead.
    // Nothing is written on a reset edge, including a coincident write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_en) begin
                regs_q[clr_ptr_q] <= '0;
            end else if (wr_en) begin
                regs_q[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Per-port read select: zero register, then bypass, then storage.
    // Bypass uses raw we, which is only honoured in RUN, matching wr_en
    // except for address 0 where the zero-register check wins first.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  zero_hit;
        logic                  byp_hit;

        assign ra       = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign byp_hit  = bus.we && (bus.waddr == ra);
        assign rdata_d[i] = !run     ? '0 :
                            zero_hit ? '0 :
                            byp_hit  ? bus.wdata :
                                       regs_q[ra];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.ready   = (state_q == RUN);
    assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (32x32b/2 ports with zero register,
// 8x16b/4 ports without), a behavioural model per instance checked every
// cycle, directed literal checks, then randomized traffic with occasional
// resets.
module tb_reg_file_mp;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifa ();
    reg_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4)) ifb ();

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural models ----------------
    // Model view: after release the file counts DEPTH cycles; once that
    // many have passed it is ready and every entry is zero. Until then
    // reads give zero and any write attempt latches the drop flag.
    bit          live;
    logic [31:0] ma_regs [32];
    logic [31:0] ma_rd   [2];
    bit          ma_rdy, ma_drop;
    int          ma_cnt;
    logic [15:0] mb_regs [8];
    logic [15:0] mb_rd   [4];
    bit          mb_rdy, mb_drop;
    int          mb_cnt;

    initial live = 1'b0;

    always @(posedge clk) begin
        logic [4:0] aa;
        logic [2:0] ab;
        if (!rst_n) begin
            live = 1'b1;
            ma_cnt = 0; ma_rdy = 1'b0; ma_drop = 1'b0;
            mb_cnt = 0; mb_rdy = 1'b0; mb_drop = 1'b0;
            for (int p = 0; p < 2; p++) ma_rd[p] = '0;
            for (int p = 0; p < 4; p++) mb_rd[p] = '0;
        end else begin
            if (!ma_rdy) begin
                if (ifa.we) ma_drop = 1'b1;
                for (int p = 0; p < 2; p++) ma_rd[p] = '0;
                ma_cnt++;
                if (ma_cnt == 32) begin
                    ma_rdy = 1'b1;
                    for (int k = 0; k < 32; k++) ma_regs[k] = '0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    aa = ifa.raddr[p*5 +: 5];
                    if (aa == 5'd0) ma_rd[p] = '0;
                    else if (ifa.we && ifa.waddr == aa) ma_rd[p] = ifa.wdata;
                    else ma_rd[p] = ma_regs[aa];
                end
                if (ifa.we && ifa.waddr != 5'd0) ma_regs[ifa.waddr] = ifa.wdata;
            end
            if (!mb_rdy) begin
                if (ifb.we) mb_drop = 1'b1;
                for (int p = 0; p < 4; p++) mb_rd[p] = '0;
                mb_cnt++;
                if (mb_cnt == 8) begin
                    mb_rdy = 1'b1;
                    for (int k = 0; k < 8; k++) mb_regs[k] = '0;
                end
            end else begin
                for (int p = 0; p < 4; p++) begin
                    ab = ifb.raddr[p*3 +: 3];
                    if (ifb.we && ifb.waddr == ab) mb_rd[p] = ifb.wdata;
                    else mb_rd[p] = mb_regs[ab];
                end
                if (ifb.we) mb_regs[ifb.waddr] = ifb.wdata;
            end
        end
    end

    // Cycle-by-cycle comparison against the models.
    always @(negedge clk) begin
        if (live) begin
            chk("a.ready", {31'd0, ifa.ready}, {31'd0, ma_rdy});
            chk("a.wr_drop", {31'd0, ifa.wr_drop}, {31'd0, ma_drop});
            for (int p = 0; p < 2; p++)
                chk($sformatf("a.rdata%0d", p), ifa.rdata[p*32 +: 32], ma_rd[p]);
            chk("b.ready", {31'd0, ifb.ready}, {31'd0, mb_rdy});
            chk("b.wr_drop", {31'd0, ifb.wr_drop}, {31'd0, mb_drop});
            for (int p = 0; p < 4; p++)
                chk($sformatf("b.rdata%0d", p), {16'd0, ifb.rdata[p*16 +: 16]}, {16'd0, mb_rd[p]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ifa.we = 1'b0; ifa.waddr = '0; ifa.wdata = '0; ifa.raddr = '0;
        ifb.we = 1'b0; ifb.waddr = '0; ifb.wdata = '0; ifb.raddr = '0;
    endtask

    // Release reset, count cycles to ready on both instances, optionally
    // poke a write into instance A during the sweep, then read every entry.
    task automatic sweep_check(input bit poke, input bit exp_drop);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            ifa.we    = poke && (k == 2);
            ifa.waddr = 5'd3;
            ifa.wdata = 32'hAA;
            step();
            chk($sformatf("a.ready@%0d", k), {31'd0, ifa.ready}, {31'd0, (k >= 32)});
            chk($sformatf("b.ready@%0d", k), {31'd0, ifb.ready}, {31'd0, (k >= 8)});
        end
        ifa.we = 1'b0;
        chk("a.wr_drop.sticky", {31'd0, ifa.wr_drop}, {31'd0, exp_drop});
        chk("b.wr_drop.clear", {31'd0, ifb.wr_drop}, 32'd0);
        for (int e = 0; e < 32; e++) begin
            ifa.raddr = {5'(31 - e), 5'(e)};
            ifb.raddr = {4{3'(e)}};
            step();
            chk($sformatf("a.zero%0d.p0", e), ifa.rdata[31:0], 32'd0);
            chk($sformatf("a.zero%0d.p1", e), ifa.rdata[63:32], 32'd0);
            chk($sformatf("b.zero%0d", e), {16'd0, ifb.rdata[15:0] | ifb.rdata[31:16] | ifb.rdata[47:32] | ifb.rdata[63:48]}, 32'd0);
        end
    endtask

    task automatic pulse_reset(input bit with_write);
        rst_n = 1'b0;
        ifa.we = with_write; ifa.waddr = 5'd9; ifa.wdata = 32'h99;
        step();
        ifa.we = 1'b0;
        chk("a.ready.in_reset", {31'd0, ifa.ready}, 32'd0);
        chk("a.rdata.in_reset", ifa.rdata[31:0], 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("a.ready.reset", {31'd0, ifa.ready}, 32'd0);
        chk("a.wr_drop.reset", {31'd0, ifa.wr_drop}, 32'd0);
        chk("a.rdata.reset", ifa.rdata[31:0], 32'd0);

        // Sweep with a write attempted to entry 3 during CLEAR.
        sweep_check(1'b1, 1'b1);

        // Write then read on both ports.
        ifa.we = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'hDEADBEEF;
        step();
        ifa.we = 1'b0; ifa.raddr = {5'd5, 5'd5};
        step();
        chk("a.rd5.p0", ifa.rdata[31:0], 32'hDEADBEEF);
        chk("a.rd5.p1", ifa.rdata[63:32], 32'hDEADBEEF);

        // Same-cycle bypass over an old value.
        ifa.we = 1'b1; ifa.waddr = 5'd7; ifa.wdata = 32'h1;
        step();
        ifa.wdata = 32'h12345678; ifa.raddr = {5'd7, 5'd5};
        step();
        chk("a.bypass7.p1", ifa.rdata[63:32], 32'h12345678);
        chk("a.bypass7.p0", ifa.rdata[31:0], 32'hDEADBEEF);
        ifa.we = 1'b0;
        step();
        chk("a.after_bypass7", ifa.rdata[63:32], 32'h12345678);

        // Hardwired zero register, including the bypass case.
        ifa.we = 1'b1; ifa.waddr = 5'd0; ifa.wdata = 32'hFFFFFFFF; ifa.raddr = '0;
        step();
        chk("a.zero_bypass.p0", ifa.rdata[31:0], 32'd0);
        chk("a.zero_bypass.p1", ifa.rdata[63:32], 32'd0);
        ifa.we = 1'b0;
        step();
        chk("a.zero_reg", ifa.rdata[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        chk("a.wr_drop.still", {31'd0, ifa.wr_drop}, 32'd1);

        // Instance B: four independent ports, and bypass at entry 0.
        for (int k = 1; k <= 4; k++) begin
            ifb.we = 1'b1; ifb.waddr = 3'(k); ifb.wdata = 16'(16'h1111 * k);
            step();
        end
        ifb.we = 1'b1; ifb.waddr = 3'd0; ifb.wdata = 16'hBEEF;
        ifb.raddr = {3'd1, 3'd0, 3'd3, 3'd4};
        step();
        ifb.we = 1'b0;
        chk("b.p0", {16'd0, ifb.rdata[15:0]},  32'h4444);
        chk("b.p1", {16'd0, ifb.rdata[31:16]}, 32'h3333);
        chk("b.p2.bypass0", {16'd0, ifb.rdata[47:32]}, 32'hBEEF);
        chk("b.p3", {16'd0, ifb.rdata[63:48]}, 32'h1111);
        ifb.raddr = {4{3'd2}};
        step();
        chk("b.same_addr", {16'd0, ifb.rdata[15:0] & ifb.rdata[31:16] & ifb.rdata[47:32] & ifb.rdata[63:48]}, 32'h2222);

        // Reset in RUN with a coincident write, then again 10 cycles into the sweep.
        pulse_reset(1'b1);
        rst_n = 1'b1;
        repeat (10) step();
        chk("a.ready.midsweep", {31'd0, ifa.ready}, 32'd0);
        pulse_reset(1'b0);
        sweep_check(1'b0, 1'b0);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            ifa.we = $urandom_range(0, 1);
            ifa.waddr = 5'($urandom);
            ifa.wdata = $urandom;
            for (int p = 0; p < 2; p++)
                ifa.raddr[p*5 +: 5] = ($urandom_range(0, 1) != 0) ? ifa.waddr : 5'($urandom);
            ifb.we = $urandom_range(0, 1);
            ifb.waddr = 3'($urandom);
            ifb.wdata = 16'($urandom);
            for (int p = 0; p < 4; p++)
                ifb.raddr[p*3 +: 3] = ($urandom_range(0, 1) != 0) ? ifb.waddr : 3'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
